instr_cache_2way: RTL and testbench

- Parametrised 2-way set-associative instruction cache for the FETCH stage. Generalises the direct-mapped fetch cache in line width, word width and set count.
- Adds LRU replacement, a registered refill FSM with a latched miss address, a whole-cache flush sweep, and saturating hit/miss counters.
- Sits between the fetch PC logic and the memory arbiter.

---
 rtl/instr_cache_2way.sv | 145 ++++++++++++++
 tb/tb_instr_cache_2way.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_2way.sv
// 2-way set-associative instruction cache for the fetch stage.
// LRU replacement, registered refill FSM with a latched miss address, flush sweep, hit/miss counters.
module instr_cache_2way #(
  parameter int cache_line_width = 256,
  parameter int word_width       = 16,
  parameter int addr_width       = 16,
  parameter int num_sets         = 4,
  parameter int cnt_width        = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [addr_width-1:0]       address,
  input  logic                        petFromProc,
  input  logic                        flush,
  input  logic                        memServiceReady,
  input  logic [cache_line_width-1:0] dataReadFromMem,
  output logic [word_width-1:0]       instructionBits,
  output logic                        isHit,
  output logic [addr_width-1:0]       addrToArb,
  output logic                        petitionToArb,
  output logic                        busy,
  output logic [cnt_width-1:0]        hitCount,
  output logic [cnt_width-1:0]        missCount
);

  localparam int WORDS = cache_line_width / word_width;
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(num_sets);
  localparam int TAG_W = addr_width - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

  state_t                      state_q, state_d;
  logic                        flush_pend_q, flush_pend_d;
  logic [addr_width-1:0]       miss_addr_q;
  logic [IDX_W-1:0]            flush_idx_q;
  logic [cnt_width-1:0]        hit_cnt_q, miss_cnt_q;
  logic [1:0]                  valid_q [num_sets];
  logic                        lru_q   [num_sets];
  logic [TAG_W-1:0]            tag_q   [num_sets][2];
  logic [cache_line_width-1:0] data_q  [num_sets][2];

  logic [OFF_W-1:0]            a_off;
  logic [IDX_W-1:0]            a_idx, m_idx;
  logic [TAG_W-1:0]            a_tag, m_tag;
  logic                        hit0, hit1, lookup_hit, hit_way;
  logic                        victim, do_hit, fill, load_miss, flush_last;
  logic [cache_line_width-1:0] hit_line;

  assign a_off = address[OFF_W-1:0];
  assign a_idx = address[OFF_W +: IDX_W];
  assign a_tag = address[addr_width-1 -: TAG_W];
  assign m_idx = miss_addr_q[OFF_W +: IDX_W];
  assign m_tag = miss_addr_q[addr_width-1 -: TAG_W];

  assign hit0       = valid_q[a_idx][0] && (tag_q[a_idx][0] == a_tag);
  assign hit1       = valid_q[a_idx][1] && (tag_q[a_idx][1] == a_tag);
  assign lookup_hit = hit0 || hit1;
  assign hit_way    = !hit0;
  assign hit_line   = data_q[a_idx][hit_way];

  // Fill an empty way first (way0 before way1); only evict when both are live.
  assign victim = !valid_q[m_idx][0] ? 1'b0 :
                  !valid_q[m_idx][1] ? 1'b1 : lru_q[m_idx];

  assign do_hit     = (state_q == IDLE) && petFromProc && lookup_hit;
  assign fill       = (state_q == REFILL) && memServiceReady;
  assign flush_last = (flush_idx_q == IDX_W'(num_sets - 1));

  assign isHit           = (state_q == IDLE) && lookup_hit;
  assign instructionBits = isHit ? hit_line[a_off*word_width +: word_width] : '0;
  assign petitionToArb   = (state_q == REFILL);
  assign addrToArb       = (state_q == REFILL) ?
                           {miss_addr_q[addr_width-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign busy            = (state_q != IDLE);
  assign hitCount        = hit_cnt_q;
  assign missCount       = miss_cnt_q;

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    load_miss    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush || flush_pend_q) begin
          state_d      = FLUSH;
          flush_pend_d = 1'b0;
        end else if (petFromProc && !lookup_hit) begin
          state_d   = REFILL;
          load_miss = 1'b1;
        end
      end
      REFILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (memServiceReady) state_d = IDLE;
      end
      FLUSH: begin
        if (flush_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      flush_pend_q <= 1'b0;
      miss_addr_q  <= '0;
      flush_idx_q  <= '0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int s = 0; s < num_sets; s++) begin
        valid_q[s] <= '0;
        lru_q[s]   <= 1'b0;
      end
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      if (load_miss) miss_addr_q <= address;
      if (do_hit) begin
        lru_q[a_idx] <= ~hit_way;
        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
      end
      if (fill) begin
        valid_q[m_idx][victim] <= 1'b1;
        lru_q[m_idx]           <= ~victim;
        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
      if (state_q == FLUSH) begin
        valid_q[flush_idx_q] <= '0;
        lru_q[flush_idx_q]   <= 1'b0;
        flush_idx_q          <= flush_last ? '0 : flush_idx_q + 1'b1;
      end
    end
  end

  // Tag and line storage carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[m_idx][victim]  <= m_tag;
      data_q[m_idx][victim] <= dataReadFromMem;
    end
  end

endmodule

// File: tb/tb_instr_cache_2way.sv
// Directed bench for instr_cache_2way: vector table for the hit/miss/LRU flow,
// hand sequences for flush, flush-during-refill, address change and reset mid-refill.
module tb_instr_cache_2way;

  logic         clk;
  logic         reset;
  logic [15:0]  address;
  logic         petFromProc;
  logic         flush;
  logic         memServiceReady;
  logic [255:0] dataReadFromMem;
  logic [15:0]  instructionBits;
  logic         isHit;
  logic [15:0]  addrToArb;
  logic         petitionToArb;
  logic         busy;
  logic [15:0]  hitCount;
  logic [15:0]  missCount;

  int checks   = 0;
  int failures = 0;

  instr_cache_2way dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .petFromProc     (petFromProc),
    .flush           (flush),
    .memServiceReady (memServiceReady),
    .dataReadFromMem (dataReadFromMem),
    .instructionBits (instructionBits),
    .isHit           (isHit),
    .addrToArb       (addrToArb),
    .petitionToArb   (petitionToArb),
    .busy            (busy),
    .hitCount        (hitCount),
    .missCount       (missCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic        pet;
    logic        fl;
    logic        rdy;
    logic [15:0] base;
    logic        hit;
    logic [15:0] instr;
    logic        parb;
    logic [15:0] arb;
    logic        bsy;
    logic [15:0] hc;
    logic [15:0] mc;
  } vec_t;

  vec_t vt [17];

  function automatic vec_t v(logic [15:0] addr, logic pet, logic fl, logic rdy,
                             logic [15:0] base, logic hit, logic [15:0] instr,
                             logic parb, logic [15:0] arb, logic bsy,
                             logic [15:0] hc, logic [15:0] mc);
    vec_t r;
    r.addr = addr; r.pet = pet; r.fl = fl; r.rdy = rdy; r.base = base;
    r.hit = hit; r.instr = instr; r.parb = parb; r.arb = arb; r.bsy = bsy;
    r.hc = hc; r.mc = mc;
    return r;
  endfunction

  // Word k of a refill line is base+k.
  function automatic logic [255:0] mkline(logic [15:0] base);
    logic [255:0] l;
    for (int k = 0; k < 16; k++) l[k*16 +: 16] = base + 16'(k);
    return l;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [15:0] a, logic p, logic f, logic r, logic [15:0] b);
    address         = a;
    petFromProc     = p;
    flush           = f;
    memServiceReady = r;
    dataReadFromMem = mkline(b);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  int nbusy;

  initial begin
    //        addr    pet   fl    rdy   base     hit   instr    parb  arb      bsy   hc  mc
    vt[0]  = v(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 0);
    vt[1]  = v(16'h0013, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 0, 0);
    vt[2]  = v(16'h0013, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b1, 0, 0);
    vt[3]  = v(16'h0013, 1'b1, 1'b0, 1'b1, 16'hBEEC, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b1, 0, 0);
    vt[4]  = v(16'h0013, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 0, 1);
    vt[5]  = v(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEC, 1'b0, 16'h0000, 1'b0, 1, 1);
    vt[6]  = v(16'h0050, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 2, 1);
    vt[7]  = v(16'h0050, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0050, 1'b1, 2, 1);
    vt[8]  = v(16'h0050, 1'b1, 1'b0, 1'b1, 16'h5000, 1'b0, 16'h0000, 1'b1, 16'h0050, 1'b1, 2, 1);
    vt[9]  = v(16'h0052, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5002, 1'b0, 16'h0000, 1'b0, 2, 2);
    vt[10] = v(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEC, 1'b0, 16'h0000, 1'b0, 3, 2);
    vt[11] = v(16'h0090, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 4, 2);
    vt[12] = v(16'h0090, 1'b1, 1'b0, 1'b1, 16'h9000, 1'b0, 16'h0000, 1'b1, 16'h0090, 1'b1, 4, 2);
    vt[13] = v(16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEC, 1'b0, 16'h0000, 1'b0, 4, 3);
    vt[14] = v(16'h0091, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h9001, 1'b0, 16'h0000, 1'b0, 4, 3);
    vt[15] = v(16'h0050, 1'b0, 1'b0, 1'b1, 16'h7700, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 5, 3);
    vt[16] = v(16'h0050, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 5, 3);

    reset = 1'b0;
    drive(16'h0013, 1'b1, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("reset isHit", 32'(isHit), 0);
    chk("reset petitionToArb", 32'(petitionToArb), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset counts", {hitCount, missCount}, 0);
    drive(16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(vt[i].addr, vt[i].pet, vt[i].fl, vt[i].rdy, vt[i].base);
      #1;
      chk($sformatf("v%0d isHit", i),           32'(isHit),           32'(vt[i].hit));
      chk($sformatf("v%0d instructionBits", i), 32'(instructionBits), 32'(vt[i].instr));
      chk($sformatf("v%0d petitionToArb", i),   32'(petitionToArb),   32'(vt[i].parb));
      chk($sformatf("v%0d addrToArb", i),       32'(addrToArb),       32'(vt[i].arb));
      chk($sformatf("v%0d busy", i),            32'(busy),            32'(vt[i].bsy));
      chk($sformatf("v%0d hitCount", i),        32'(hitCount),        32'(vt[i].hc));
      chk($sformatf("v%0d missCount", i),       32'(missCount),       32'(vt[i].mc));
      step();
    end

    // Flush of a warm cache: exactly 4 busy cycles; a second pulse mid-sweep is ignored.
    drive(16'h0010, 1'b0, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("flush entry isHit", 32'(isHit), 1);
    step();
    for (int c = 0; c < 4; c++) begin
      drive(16'h0010, 1'b0, (c == 1), 1'b0, 16'h0000);
      #1;
      chk($sformatf("flush c%0d busy", c), 32'(busy), 1);
      chk($sformatf("flush c%0d isHit", c), 32'(isHit), 0);
      chk($sformatf("flush c%0d petitionToArb", c), 32'(petitionToArb), 0);
      step();
    end
    drive(16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("post-flush busy", 32'(busy), 0);
    chk("post-flush 0x10 isHit", 32'(isHit), 0);
    chk("post-flush counts", {hitCount, missCount}, {16'd5, 16'd3});
    step();

    // Flush arriving while a refill waits for the arbiter.
    drive(16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("fdr miss isHit", 32'(isHit), 0);
    step();
    drive(16'h0020, 1'b1, 1'b1, 1'b0, 16'h0000);
    #1;
    chk("fdr flush addrToArb", 32'(addrToArb), 32'h0020);
    chk("fdr flush busy", 32'(busy), 1);
    step();
    for (int c = 0; c < 2; c++) begin
      drive(16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000);
      #1;
      chk($sformatf("fdr wait%0d petitionToArb", c), 32'(petitionToArb), 1);
      step();
    end
    drive(16'h0020, 1'b1, 1'b0, 1'b1, 16'h2000);
    #1;
    chk("fdr ready petitionToArb", 32'(petitionToArb), 1);
    step();
    drive(16'h0020, 1'b0, 1'b0, 1'b0, 16'h0000);
    nbusy = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (c == 0) chk("fdr missCount", 32'(missCount), 4);
      if (busy) begin
        nbusy++;
        chk($sformatf("fdr sweep c%0d isHit", c), 32'(isHit), 0);
      end
      step();
    end
    chk("fdr sweep length", 32'(nbusy), 4);
    #1;
    chk("fdr refilled line flushed", 32'(isHit), 0);
    step();

    // Address changes while the refill is pending do not redirect it.
    drive(16'h0020, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    drive(16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("achg addrToArb a", 32'(addrToArb), 32'h0020);
    step();
    drive(16'h0100, 1'b1, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("achg addrToArb b", 32'(addrToArb), 32'h0020);
    chk("achg isHit", 32'(isHit), 0);
    step();
    drive(16'h0100, 1'b1, 1'b0, 1'b1, 16'h2200);
    #1;
    chk("achg ready addrToArb", 32'(addrToArb), 32'h0020);
    step();
    drive(16'h0022, 1'b1, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("achg 0x22 isHit", 32'(isHit), 1);
    chk("achg 0x22 instructionBits", 32'(instructionBits), 32'h2202);
    chk("achg counts", {hitCount, missCount}, {16'd5, 16'd5});
    step();
    drive(16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("achg 0x100 isHit", 32'(isHit), 0);
    chk("achg hitCount", 32'(hitCount), 6);
    step();

    // Reset mid-refill, with the arbiter answering during reset.
    drive(16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000);
    step();
    #1;
    chk("rmr petitionToArb", 32'(petitionToArb), 1);
    drive(16'h0010, 1'b1, 1'b0, 1'b1, 16'h1230);
    reset = 1'b0;
    #1;
    chk("rmr async petitionToArb", 32'(petitionToArb), 0);
    chk("rmr async addrToArb", 32'(addrToArb), 0);
    chk("rmr async busy", 32'(busy), 0);
    chk("rmr async isHit", 32'(isHit), 0);
    chk("rmr async instructionBits", 32'(instructionBits), 0);
    chk("rmr async counts", {hitCount, missCount}, 0);
    step();
    reset = 1'b1;
    drive(16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("rmr after isHit", 32'(isHit), 0);
    chk("rmr after busy", 32'(busy), 0);
    step();
    drive(16'h0013, 1'b1, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("rmr 0x13 isHit", 32'(isHit), 0);
    step();
    #1;
    chk("rmr re-refill petitionToArb", 32'(petitionToArb), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
